player_ctrl: RTL and testbench

Player-plane controller for the VGA plane game. It sits directly downstream of the button debounce/edge-detect stage and consumes its one-cycle `up/down/left/right/shoot` pulses. It keeps the plane position, clamped to the screen, and manages a small fixed pool of player bullets with a fire cooldown. It advances the bullets once per video frame and exposes positions to the renderer.

---
 rtl/plane_pkg.sv | 40 ++++
 rtl/player_ctrl_if.sv | 29 ++
 rtl/player_bullet_slot.sv | 47 ++++
 rtl/player_ctrl.sv | 112 +++++++++++
 tb/tb_player_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/plane_pkg.sv
// Shared types and constants for the player plane: screen geometry, coordinates, bullet record.
// The saturating helpers keep every coordinate on screen without wrapping.
package plane_pkg;

  localparam int unsigned ScreenW = 640;
  localparam int unsigned ScreenH = 480;
  localparam int unsigned PlaneW  = 32;
  localparam int unsigned PlaneH  = 32;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic   valid;
    coord_t x;
    coord_t y;
  } bullet_t;

  // Plane starts horizontally centred, a small margin above the bottom edge.
  function automatic coord_t reset_x(int unsigned sw, int unsigned pw);
    return coord_t'((sw - pw) / 2);
  endfunction

  function automatic coord_t reset_y(int unsigned sh, int unsigned ph);
    return coord_t'(sh - ph - 8);
  endfunction

  localparam coord_t SpawnX = reset_x(ScreenW, PlaneW);
  localparam coord_t SpawnY = reset_y(ScreenH, PlaneH);

  function automatic coord_t sat_sub(coord_t a, coord_t b);
    return (a >= b) ? a - b : '0;
  endfunction

  function automatic coord_t sat_add(coord_t a, coord_t b, coord_t max);
    logic [10:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[9:0];
  endfunction

endpackage

// File: rtl/player_ctrl_if.sv
// Input pulses from the debounce stage and registered position outputs to the renderer.
interface player_ctrl_if
  import plane_pkg::*;
#(
  parameter int unsigned NB = 4
);
  logic             frame_tick;
  logic             up;
  logic             down;
  logic             left;
  logic             right;
  logic             shoot;
  coord_t           plane_x;
  coord_t           plane_y;
  logic [NB-1:0]    bullet_valid;
  logic [10*NB-1:0] bullet_x;
  logic [10*NB-1:0] bullet_y;
  logic             fire;

  modport master (
    output frame_tick, up, down, left, right, shoot,
    input  plane_x, plane_y, bullet_valid, bullet_x, bullet_y, fire
  );

  modport slave (
    input  frame_tick, up, down, left, right, shoot,
    output plane_x, plane_y, bullet_valid, bullet_x, bullet_y, fire
  );
endinterface

// File: rtl/player_bullet_slot.sv
// One bullet slot: loads at a spawn point, rises BSPEED pixels per tick, frees itself at the top.
module player_bullet_slot
  import plane_pkg::*;
#(
  parameter int unsigned BSPEED = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  coord_t load_x,
  input  coord_t load_y,
  input  logic   tick,
  output logic   valid,
  output coord_t x,
  output coord_t y
);
  localparam coord_t Speed = coord_t'(BSPEED);

  bullet_t b_q, b_d;

  // Load is only issued to a free slot, so it never collides with an advance.
  always_comb begin
    b_d = b_q;
    if (load) begin
      b_d = '{valid: 1'b1, x: load_x, y: load_y};
    end else if (tick && b_q.valid) begin
      if (b_q.y < Speed) begin
        b_d.valid = 1'b0;
      end else begin
        b_d.y = b_q.y - Speed;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q <= '0;
    end else begin
      b_q <= b_d;
    end
  end

  assign valid = b_q.valid;
  assign x     = b_q.x;
  assign y     = b_q.y;

endmodule

// File: rtl/player_ctrl.sv
// Player-plane controller: clamped plane movement, one-deep shot request, cooldown-limited
// spawning into the lowest free bullet slot.
module player_ctrl
  import plane_pkg::*;
#(
  parameter int unsigned SCREEN_W = ScreenW,
  parameter int unsigned SCREEN_H = ScreenH,
  parameter int unsigned PLANE_W  = PlaneW,
  parameter int unsigned PLANE_H  = PlaneH,
  parameter int unsigned STEP     = 8,
  parameter int unsigned NB       = 4,
  parameter int unsigned BSPEED   = 4,
  parameter int unsigned COOLDOWN = 8
) (
  input logic          clk,
  input logic          rst,
  player_ctrl_if.slave bus
);
  localparam int unsigned        CdW     = $clog2(COOLDOWN + 1);
  localparam coord_t             MaxX    = coord_t'(SCREEN_W - PLANE_W);
  localparam coord_t             MaxY    = coord_t'(SCREEN_H - PLANE_H);
  localparam coord_t             Step    = coord_t'(STEP);
  localparam coord_t             MuzzleX = coord_t'(PLANE_W / 2 - 1);
  localparam coord_t             MuzzleY = coord_t'(4);
  localparam logic [CdW-1:0]     CdLoad  = CdW'(COOLDOWN);

  coord_t         px_q, px_d, py_q, py_d;
  logic           pend_q, pend_d;
  logic [CdW-1:0] cd_q, cd_d;
  logic           fire_q;

  logic [NB-1:0]  valid, free, pick, load;
  logic           spawn;
  coord_t         load_x, load_y;
  coord_t         slot_x [NB];
  coord_t         slot_y [NB];

  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (bus.left && !bus.right) begin
      px_d = sat_sub(px_q, Step);
    end else if (bus.right && !bus.left) begin
      px_d = sat_add(px_q, Step, MaxX);
    end
    if (bus.up && !bus.down) begin
      py_d = sat_sub(py_q, Step);
    end else if (bus.down && !bus.up) begin
      py_d = sat_add(py_q, Step, MaxY);
    end
  end

  // Free set is taken before this cycle's tick, so a slot freed now is reused next cycle.
  assign free   = ~valid;
  assign pick   = free & (~free + NB'(1));
  assign spawn  = (bus.shoot || pend_q) && (cd_q == '0) && (|free);
  assign load   = spawn ? pick : '0;
  assign load_x = px_q + MuzzleX;
  assign load_y = sat_sub(py_q, MuzzleY);

  always_comb begin
    cd_d   = cd_q;
    pend_d = pend_q;
    if (spawn) begin
      cd_d   = CdLoad;
      pend_d = 1'b0;
    end else begin
      if (bus.frame_tick && cd_q != '0) cd_d = cd_q - 1'b1;
      if (bus.shoot) pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      px_q   <= reset_x(SCREEN_W, PLANE_W);
      py_q   <= reset_y(SCREEN_H, PLANE_H);
      pend_q <= 1'b0;
      cd_q   <= '0;
      fire_q <= 1'b0;
    end else begin
      px_q   <= px_d;
      py_q   <= py_d;
      pend_q <= pend_d;
      cd_q   <= cd_d;
      fire_q <= spawn;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_slot
    player_bullet_slot #(
      .BSPEED(BSPEED)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .load_x(load_x),
      .load_y(load_y),
      .tick  (bus.frame_tick),
      .valid (valid[i]),
      .x     (slot_x[i]),
      .y     (slot_y[i])
    );
    assign bus.bullet_x[10*i +: 10] = slot_x[i];
    assign bus.bullet_y[10*i +: 10] = slot_y[i];
  end

  assign bus.plane_x      = px_q;
  assign bus.plane_y      = py_q;
  assign bus.bullet_valid = valid;
  assign bus.fire         = fire_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: directed scenarios plus random pulses against an
// integer-level game model; expected snapshots are queued and checked by a separate monitor.
module tb_player_ctrl;
  import plane_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  player_ctrl_if #(.NB(4)) bus ();

  player_ctrl #(
    .SCREEN_W(640), .SCREEN_H(480), .PLANE_W(32), .PLANE_H(32),
    .STEP(8), .NB(4), .BSPEED(4), .COOLDOWN(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0] due;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [3:0]  v;
    logic [39:0] bx;
    logic [39:0] by;
    logic        fire;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Game model in plain integers.
  int m_px, m_py, m_cd;
  bit m_pend, m_fire;
  bit m_v[4];
  int m_bx[4];
  int m_by[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic model_reset();
    m_px = 304; m_py = 440; m_cd = 0; m_pend = 0; m_fire = 0;
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 0; m_bx[i] = 0; m_by[i] = 0;
    end
  endtask

  task automatic model_step(input bit r, input bit t, input bit u, input bit d,
                            input bit l, input bit rt, input bit s);
    int k;
    bit sp;
    int opx, opy;
    if (r) begin
      model_reset();
      return;
    end
    k = -1;
    for (int i = 0; i < 4; i++) if (!m_v[i] && k < 0) k = i;
    sp  = (s || m_pend) && m_cd == 0 && k >= 0;
    opx = m_px;
    opy = m_py;
    if (t) begin
      for (int i = 0; i < 4; i++) begin
        if (m_v[i]) begin
          if (m_by[i] < 4) m_v[i] = 0;
          else m_by[i] = m_by[i] - 4;
        end
      end
    end
    if (sp) m_cd = 8;
    else if (t && m_cd > 0) m_cd = m_cd - 1;
    if (sp) begin
      m_v[k]  = 1;
      m_bx[k] = opx + 15;
      m_by[k] = (opy >= 4) ? opy - 4 : 0;
      m_pend  = 0;
    end else if (s) begin
      m_pend = 1;
    end
    if (u && !d) m_py = (m_py >= 8) ? m_py - 8 : 0;
    if (d && !u) m_py = (m_py + 8 > 448) ? 448 : m_py + 8;
    if (l && !rt) m_px = (m_px >= 8) ? m_px - 8 : 0;
    if (rt && !l) m_px = (m_px + 8 > 608) ? 608 : m_px + 8;
    m_fire = sp;
  endtask

  task automatic step(input bit r, input bit t, input bit u, input bit d,
                      input bit l, input bit rt, input bit s);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.frame_tick = t; bus.up = u; bus.down = d;
    bus.left = l; bus.right = rt; bus.shoot = s;
    model_step(r, t, u, d, l, rt, s);
    e.due  = 32'(cyc + 1);
    e.px   = 10'(m_px);
    e.py   = 10'(m_py);
    e.fire = m_fire;
    for (int i = 0; i < 4; i++) begin
      e.v[i]          = m_v[i];
      e.bx[10*i +: 10] = 10'(m_bx[i]);
      e.by[10*i +: 10] = 10'(m_by[i]);
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every edge the DUT presents a new registered snapshot.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && int'(sb[0].due) <= cyc) begin
      e = sb.pop_front();
      chk("plane_x", int'(bus.plane_x), int'(e.px));
      chk("plane_y", int'(bus.plane_y), int'(e.py));
      chk("bullet_valid", int'(bus.bullet_valid), int'(e.v));
      chk("fire", int'(bus.fire), int'(e.fire));
      for (int i = 0; i < 4; i++) begin
        if (e.v[i]) begin
          chk($sformatf("bullet_x[%0d]", i), int'(bus.bullet_x[10*i +: 10]),
              int'(e.bx[10*i +: 10]));
          chk($sformatf("bullet_y[%0d]", i), int'(bus.bullet_y[10*i +: 10]),
              int'(e.by[10*i +: 10]));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.frame_tick = 0; bus.up = 0; bus.down = 0;
    bus.left = 0; bus.right = 0; bus.shoot = 0;
    model_reset();

    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    @(posedge clk); #1;
    chk("reset plane_x", int'(bus.plane_x), 304);
    chk("reset plane_y", int'(bus.plane_y), 440);
    chk("reset valid", int'(bus.bullet_valid), 0);
    chk("reset bullet_x", int'(bus.bullet_x), 0);
    chk("reset bullet_y", int'(bus.bullet_y), 0);

    // Walk left into the wall.
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    chk("left clamp x", int'(bus.plane_x), 0);
    chk("left clamp y", int'(bus.plane_y), 440);

    // Down clamp, then opposing vertical pulses.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 1, 0);
    @(posedge clk); #1;
    chk("down clamp y", int'(bus.plane_y), 448);

    // Single shot from reset, then one frame.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("shot fire", int'(bus.fire), 1);
    chk("shot x0", int'(bus.bullet_x[9:0]), 319);
    chk("shot y0", int'(bus.bullet_y[9:0]), 436);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(2);

    // Shoot every frame; extra request waits for a slot to clear.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int f = 0; f < 40; f++) begin
      step(0, 1, 0, 0, 0, 0, 1);
      idle(3);
    end
    ticks(300);

    // Spawn and tick in the same cycle with slot 0 at y=100.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 38; i++) step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    ticks(8);
    step(0, 1, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("same-cycle y0", int'(bus.bullet_y[9:0]), 96);
    chk("same-cycle y1", int'(bus.bullet_y[19:10]), 132);
    step(0, 0, 0, 0, 0, 0, 1);
    ticks(9);
    idle(2);

    // Reset with three bullets live and a pending shot.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    ticks(8);
    step(0, 0, 0, 0, 0, 0, 1);
    ticks(8);
    step(0, 0, 0, 0, 0, 0, 1);
    ticks(1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("rst fire", int'(bus.fire), 0);
    chk("rst valid", int'(bus.bullet_valid), 0);
    idle(12);

    // Random pulses with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0);
    end
    idle(1);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    chk("scoreboard drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
